// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage CPU: datapath widths, reset defaults
// and the instruction-fetch state encoding.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0040_0000;
  localparam logic [ILEN-1:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP       = 32'd4;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'b00,
    FETCH_HOLD = 2'b01,
    FETCH_DROP = 2'b10
  } fetch_state_e;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding req/ack
// instruction-memory port and feeds the IF/ID register.
module if_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [ILEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            valid_if,
  output logic [XLEN-1:0] npc_if,
  output logic [ILEN-1:0] instr_if
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic [ILEN-1:0] hold_instr_q, hold_instr_d;
  logic [XLEN-1:0] target_pc;
  logic [XLEN-1:0] pc_plus4;

  assign target_pc = align_word(redirect_pc);
  assign pc_plus4  = pc_q + PC_STEP;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    hold_instr_d = hold_instr_q;
    unique case (state_q)
      FETCH_REQ: begin
        if (imem_ack) begin
          if (redirect) begin
            pc_d = target_pc;
          end else if (stall) begin
            hold_instr_d = imem_rdata;
            state_d      = FETCH_HOLD;
          end else begin
            pc_d = pc_plus4;
          end
        end else if (redirect) begin
          pend_pc_d = target_pc;
          state_d   = FETCH_DROP;
        end
      end
      FETCH_HOLD: begin
        if (redirect) begin
          pc_d    = target_pc;
          state_d = FETCH_REQ;
        end else if (!stall) begin
          pc_d    = pc_plus4;
          state_d = FETCH_REQ;
        end
      end
      FETCH_DROP: begin
        // The in-flight fetch is wrong-path; wait out its ack, then jump.
        if (redirect) pend_pc_d = target_pc;
        if (imem_ack) begin
          pc_d    = redirect ? target_pc : pend_pc_q;
          state_d = FETCH_REQ;
        end
      end
      default: state_d = FETCH_REQ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= FETCH_REQ;
      pc_q         <= RESET_PC;
      pend_pc_q    <= '0;
      hold_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  // Reset gates the request combinationally so an in-flight fetch is
  // abandoned immediately, not at the next edge.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q;
    valid_if  = 1'b0;
    npc_if    = pc_plus4;
    instr_if  = NOP_INSTR;
    if (rst) begin
      unique case (state_q)
        FETCH_REQ: begin
          imem_req = 1'b1;
          if (imem_ack && !redirect) begin
            valid_if = 1'b1;
            instr_if = imem_rdata;
          end
        end
        FETCH_HOLD: begin
          valid_if = 1'b1;
          instr_if = hold_instr_q;
        end
        FETCH_DROP: imem_req = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: inputs change on the falling edge and
// outputs are compared 1ns later against hand-computed vectors.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        valid_if;
  logic [31:0] npc_if;
  logic [31:0] instr_if;

  int compared   = 0;
  int mismatched = 0;

  // {imem_req, imem_addr, valid_if, npc_if, instr_if}
  logic [97:0] obs;
  logic [97:0] exp_v;
  assign obs = {imem_req, imem_addr, valid_if, npc_if, instr_if};

  if_fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .valid_if   (valid_if),
    .npc_if     (npc_if),
    .instr_if   (instr_if)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic s, input logic r, input logic [31:0] rpc,
                       input logic a, input logic [31:0] rd);
    stall = s; redirect = r; redirect_pc = rpc; imem_ack = a; imem_rdata = rd;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(0, 0, 32'h0, 1, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    #1;
    exp_v = {1'b0, 32'h0040_0000, 1'b0, 32'h0040_0004, 32'h0};
    compared++; if (obs !== exp_v) begin mismatched++; $display("FAIL reset_state: got %h want %h", obs, exp_v); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_back_to_back();
    drive(0, 0, 32'h0, 1, 32'h2008_0001);
    exp_v = {1'b1, 32'h0040_0000, 1'b1, 32'h0040_0004, 32'h2008_0001};
    compared++; if (obs !== exp_v) begin mismatched++; $display("FAIL b2b_0: got %h want %h", obs, exp_v); end
    @(negedge clk); drive(0, 0, 32'h0, 1, 32'h2009_0002);
    exp_v = {1'b1, 32'h0040_0004, 1'b1, 32'h0040_0008, 32'h2009_0002};
    compared++; if (obs !== exp_v) begin mismatched++; $display("FAIL b2b_1: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_stall_hold();
    @(negedge clk); drive(1, 0, 32'h0, 1, 32'h8C01_0004);
    exp_v = {1'b1, 32'h0040_0008, 1'b1, 32'h0040_000C, 32'h8C01_0004};
    compared++; if (obs !== exp_v) begin mismatched++; $display("FAIL stall_ack: got %h want %h", obs, exp_v); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(i < 2, 0, 32'h0, 0, 32'h5555_5555);
      exp_v = {1'b0, 32'h0040_0008, 1'b1, 32'h0040_000C, 32'h8C01_0004};
      compared++; if (obs !== exp_v) begin mismatched++; $display("FAIL hold_%0d: got %h want %h", i, obs, exp_v); end
    end
    @(negedge clk); drive(0, 0, 32'h0, 0, 32'h0);
    exp_v = {1'b1, 32'h0040_000C, 1'b0, 32'h0040_0010, 32'h0};
    compared++; if (obs !== exp_v) begin mismatched++; $display("FAIL post_hold_req: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_redirect_drop();
    drive(0, 0, 32'h0, 1, 32'h0000_0020);
    @(negedge clk); drive(0, 1, 32'h0040_0100, 0, 32'h0);
    exp_v = {1'b1, 32'h0040_0010, 1'b0, 32'h0040_0014, 32'h0};
    compared++; if (obs !== exp_v) begin mismatched++; $display("FAIL drop_enter: got %h want %h", obs, exp_v); end
    @(negedge clk); drive(0, 0, 32'h0, 1, 32'hDEAD_BEEF);
    exp_v = {1'b1, 32'h0040_0010, 1'b0, 32'h0040_0014, 32'h0};
    compared++; if (obs !== exp_v) begin mismatched++; $display("FAIL drop_ack_discard: got %h want %h", obs, exp_v); end
    @(negedge clk); drive(0, 0, 32'h0, 0, 32'h0);
    exp_v = {1'b1, 32'h0040_0100, 1'b0, 32'h0040_0104, 32'h0};
    compared++; if (obs !== exp_v) begin mismatched++; $display("FAIL drop_target: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_double_redirect();
    drive(0, 1, 32'h0040_0300, 0, 32'h0);
    @(negedge clk); drive(0, 1, 32'h0040_0100, 0, 32'h0);
    exp_v = {1'b1, 32'h0040_0100, 1'b0, 32'h0040_0104, 32'h0};
    compared++; if (obs !== exp_v) begin mismatched++; $display("FAIL dbl_first: got %h want %h", obs, exp_v); end
    @(negedge clk); drive(0, 1, 32'h0040_0200, 0, 32'h0);
    @(negedge clk); drive(0, 0, 32'h0, 1, 32'h1111_1111);
    exp_v = {1'b1, 32'h0040_0100, 1'b0, 32'h0040_0104, 32'h0};
    compared++; if (obs !== exp_v) begin mismatched++; $display("FAIL dbl_ack: got %h want %h", obs, exp_v); end
    // REQ with ack and redirect together: data dropped, target word-aligned.
    @(negedge clk); drive(0, 1, 32'h0040_0031, 1, 32'h2222_2222);
    exp_v = {1'b1, 32'h0040_0200, 1'b0, 32'h0040_0204, 32'h0};
    compared++; if (obs !== exp_v) begin mismatched++; $display("FAIL dbl_latest: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_redirect_over_stall();
    @(negedge clk); drive(1, 0, 32'h0, 1, 32'h1234_5678);
    exp_v = {1'b1, 32'h0040_0030, 1'b1, 32'h0040_0034, 32'h1234_5678};
    compared++; if (obs !== exp_v) begin mismatched++; $display("FAIL ros_ack: got %h want %h", obs, exp_v); end
    @(negedge clk); drive(1, 1, 32'h0040_0043, 0, 32'h0);
    exp_v = {1'b0, 32'h0040_0030, 1'b1, 32'h0040_0034, 32'h1234_5678};
    compared++; if (obs !== exp_v) begin mismatched++; $display("FAIL ros_hold: got %h want %h", obs, exp_v); end
    @(negedge clk); drive(1, 0, 32'h0, 0, 32'h0);
    exp_v = {1'b1, 32'h0040_0040, 1'b0, 32'h0040_0044, 32'h0};
    compared++; if (obs !== exp_v) begin mismatched++; $display("FAIL ros_target: got %h want %h", obs, exp_v); end
    @(negedge clk); drive(0, 0, 32'h0, 0, 32'h0);
    compared++; if (obs !== exp_v) begin mismatched++; $display("FAIL req_stall_noack: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_npc_wrap();
    drive(0, 1, 32'hFFFF_FFFE, 1, 32'h0);
    @(negedge clk); drive(0, 0, 32'h0, 1, 32'h0BAD_F00D);
    exp_v = {1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0000_0000, 32'h0BAD_F00D};
    compared++; if (obs !== exp_v) begin mismatched++; $display("FAIL wrap_top: got %h want %h", obs, exp_v); end
    @(negedge clk); drive(0, 0, 32'h0, 0, 32'h0);
    exp_v = {1'b1, 32'h0000_0000, 1'b0, 32'h0000_0004, 32'h0};
    compared++; if (obs !== exp_v) begin mismatched++; $display("FAIL wrap_zero: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_async_reset();
    drive(0, 1, 32'h0040_0020, 1, 32'h0);
    @(negedge clk); drive(0, 0, 32'h0, 0, 32'h0);
    exp_v = {1'b1, 32'h0040_0020, 1'b0, 32'h0040_0024, 32'h0};
    compared++; if (obs !== exp_v) begin mismatched++; $display("FAIL ar_pre: got %h want %h", obs, exp_v); end
    #1; rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h3333_3333; #1;
    exp_v = {1'b0, 32'h0040_0000, 1'b0, 32'h0040_0004, 32'h0};
    compared++; if (obs !== exp_v) begin mismatched++; $display("FAIL ar_async: got %h want %h", obs, exp_v); end
    @(negedge clk); rst = 1'b1; drive(0, 0, 32'h0, 0, 32'h0);
    exp_v = {1'b1, 32'h0040_0000, 1'b0, 32'h0040_0004, 32'h0};
    compared++; if (obs !== exp_v) begin mismatched++; $display("FAIL ar_release: got %h want %h", obs, exp_v); end
    @(negedge clk); drive(0, 0, 32'h0, 1, 32'h2408_0007);
    exp_v = {1'b1, 32'h0040_0000, 1'b1, 32'h0040_0004, 32'h2408_0007};
    compared++; if (obs !== exp_v) begin mismatched++; $display("FAIL ar_first_ack: got %h want %h", obs, exp_v); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall_hold();
    test_redirect_drop();
    test_double_redirect();
    test_redirect_over_stall();
    test_npc_wrap();
    test_async_reset();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined CPU. Sits directly upstream of the IF/ID pipeline register.
- Owns the PC and drives a single-outstanding req/ack instruction-memory port.
- Absorbs hazard-unit stalls and branch/jump redirects from ID.
- Each cycle presents npc_if (PC+4) and instr_if to the IF/ID register, with a NOP bubble when no instruction is available.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word emitted as a bubble.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- stall  input  1  hazard unit: IF/ID must not advance this cycle.
- redirect  input  1  ID: control transfer resolved; fetch from redirect_pc next.
- redirect_pc  input  32  redirect target; bits [1:0] ignored (forced 00).
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address; word aligned.
- imem_ack  input  1  memory accepts the request; imem_rdata valid this cycle. May assert in the same cycle as imem_req.
- imem_rdata  input  32  fetched instruction.
- valid_if  output  1  instr_if carries a real instruction this cycle.
- npc_if  output  32  PC+4 of the instruction on instr_if.
- instr_if  output  32  instruction to IF/ID; NOP_INSTR when valid_if=0.

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC, state=REQ, hold_instr=0, pend_pc=0.
  - imem_req=0 while rst=0 (gated), valid_if=0, instr_if=NOP_INSTR, npc_if=RESET_PC+4.
- Protocol: once imem_req rises, imem_addr stays stable until the cycle imem_ack=1. At most one request is outstanding.
- Priority: redirect > stall in every state.
- npc_if = pc+4, modulo 2^32 (wraps at 32'hFFFF_FFFC -> 0).
- State REQ (imem_req=1, imem_addr=pc):
  - ack & redirect: discard rdata; valid_if=0; pc<=redirect_pc; stay REQ.
  - ack & stall: valid_if=1, instr_if=imem_rdata; hold_instr<=imem_rdata; go HOLD.
  - ack, no stall/redirect: valid_if=1, instr_if=imem_rdata; pc<=pc+4; stay REQ (back-to-back fetch; zero-wait memory gives 1 instr/cycle).
  - no ack & redirect: valid_if=0; pend_pc<=redirect_pc; go DROP.
  - no ack, otherwise: valid_if=0; stay REQ.
- State HOLD (imem_req=0):
  - valid_if=1, instr_if=hold_instr, npc_if=pc+4, held stable across stall cycles.
  - redirect: pc<=redirect_pc; go REQ.
  - !stall: pc<=pc+4; go REQ.
  - stall: stay HOLD.
- State DROP (imem_req=1, imem_addr=old pc, valid_if=0):
  - redirect (any cycle): pend_pc<=redirect_pc (latest wins).
  - ack: discard rdata; pc<=(redirect ? redirect_pc : pend_pc); go REQ.
- Stall in REQ with no ack: no effect (valid_if=0 already).
- Reset mid-request: abandon the request immediately. Memory must tolerate imem_req dropping without ack.
- Redirect target alignment: pc[1:0] always 00.
- Latency: redirect at cycle t -> first request to the target at t+1 (REQ/HOLD), or the cycle after the pending ack (DROP).

Decomposition:
- Shared package cpu_pkg:
  - fetch state encoding (REQ, HOLD, DROP; 2-bit)
  - NOP_INSTR and RESET_PC defaults
  - PC width / instruction width constants
- No sub-module. PC adder and next-PC mux are inline. The FSM, pc, hold_instr and pend_pc live in one always block plus a combinational output block.

Test Plan:
- Reset release, memory acks same cycle, no stall -> imem_addr 0x00400000, 0x00400004, 0x00400008 on consecutive cycles. valid_if=1 each cycle with matching rdata; npc_if=0x00400004, 0x00400008, ...
- Stall 3 cycles coincident with ack of instr 0x8C010004 at pc 0x00400008 -> instr_if=0x8C010004 and npc_if=0x0040000C held 4 cycles, imem_req=0 during HOLD. Next request to 0x0040000C on the cycle after stall drops.
- Memory with 2-cycle ack latency; redirect to 0x00400100 in first wait cycle -> imem_addr stays 0x00400010 until ack, that rdata is dropped (valid_if=0), next request is 0x00400100.
- Two redirects during DROP (0x00400100 then 0x00400200) -> post-ack fetch address 0x00400200.
- Redirect and stall asserted same cycle in HOLD, redirect_pc=0x00400043 -> stall ignored, next imem_addr=0x00400040.
- Assert rst=0 asynchronously mid-request with pc=0x00400020 -> imem_req, valid_if drop immediately. After release, first imem_addr=0x00400000, instr_if=NOP_INSTR until first ack.
